// File: rtl/led_bar_meter_pkg.sv
// Shared types and helpers for the LED bar meter: FSM state encoding,
// mode constants and a constant-foldable ceil(log2) used for port widths.
package led_meter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HOLD  = 2'd1,
      DECAY = 2'd2
   } state_e;

   localparam logic MODE_TRACK = 1'b0;
   localparam logic MODE_PEAK  = 1'b1;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int p = 1; p < v; p = p * 2) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/led_bar_meter_if.sv
// Sample/control inputs and bar outputs of the LED bar meter, bundled so the
// producer side (master) and the meter (slave) share one definition.
interface led_bar_meter_if
   import led_meter_pkg::*;
#(
   parameter int IN_W   = 2,
   parameter int N_LEDS = 6,
   parameter int LVL_W  = clog2(N_LEDS + 1)
);
   logic              valid;
   logic [IN_W-1:0]   v1;
   logic [IN_W-1:0]   v2;
   logic              mode;
   logic              clr_ovf;
   logic [N_LEDS-1:0] L14;
   logic [LVL_W-1:0]  level;
   logic              ovf;

   modport master (output valid, v1, v2, mode, clr_ovf,
                   input  L14, level, ovf);
   modport slave  (input  valid, v1, v2, mode, clr_ovf,
                   output L14, level, ovf);
endinterface

// File: rtl/led_bar_meter_therm_enc.sv
// Level to thermometer decoder: bit i is lit whenever level exceeds i.
module therm_enc #(
   parameter int N_LEDS = 6,
   parameter int LVL_W  = 3
) (
   input  logic [LVL_W-1:0]  level,
   output logic [N_LEDS-1:0] therm
);

   always_comb begin
      therm = '0;
      for (int i = 0; i < N_LEDS; i++) therm[i] = (32'(level) > i);
   end

endmodule

// File: rtl/led_bar_meter.sv
// LED bar meter: saturating sum of two operands shown as a thermometer bar,
// either tracking each sample or holding the peak and decaying it slowly.
module led_bar_meter
   import led_meter_pkg::*;
#(
   parameter int IN_W      = 2,
   parameter int N_LEDS    = 6,
   parameter int HOLD_CYC  = 8,
   parameter int DECAY_DIV = 4,
   parameter int LVL_W     = clog2(N_LEDS + 1)
) (
   input logic            clk,
   input logic            rst,
   led_bar_meter_if.slave bus
);

   localparam int HC_W = clog2(HOLD_CYC + 1);
   localparam int DC_W = clog2(DECAY_DIV + 1);

   localparam logic [1:0] ST_IDLE  = IDLE;
   localparam logic [1:0] ST_HOLD  = HOLD;
   localparam logic [1:0] ST_DECAY = DECAY;

   function automatic logic [LVL_W-1:0] sat_sum(input logic [IN_W:0] s);
      if (32'(s) > N_LEDS) return LVL_W'(N_LEDS);
      return LVL_W'(s);
   endfunction

   logic [IN_W:0]      sum;
   logic [LVL_W-1:0]   sample;
   logic               sum_over;
   logic               mode_chg;

   logic [LVL_W-1:0]   level_q, level_d;
   logic [1:0]         state_q, state_d;
   logic [HC_W-1:0]    hold_cnt_q, hold_cnt_d;
   logic [DC_W-1:0]    div_cnt_q, div_cnt_d;
   logic               ovf_q, ovf_d;
   logic               mode_q, mode_d;
   logic               mode_vld_q, mode_vld_d;

   assign sum      = {1'b0, bus.v1} + {1'b0, bus.v2};
   assign sample   = sat_sum(sum);
   assign sum_over = (32'(sum) > N_LEDS);
   // The first edge after reset only learns the mode; it is not a mode change.
   assign mode_chg = mode_vld_q && (bus.mode != mode_q);

   always_comb begin
      level_d    = level_q;
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      div_cnt_d  = div_cnt_q;
      mode_d     = bus.mode;
      mode_vld_d = 1'b1;
      ovf_d      = ovf_q;

      if (bus.valid && sum_over) ovf_d = 1'b1;
      else if (bus.clr_ovf)      ovf_d = 1'b0;

      if (mode_chg || bus.mode == MODE_TRACK) begin
         state_d    = ST_IDLE;
         hold_cnt_d = '0;
         div_cnt_d  = '0;
         if (!mode_chg && bus.valid) level_d = sample;
      end else if (bus.valid && sample >= level_q) begin
         // Capture beats any decay step due on this edge.
         level_d    = sample;
         state_d    = ST_HOLD;
         hold_cnt_d = '0;
         div_cnt_d  = '0;
      end else begin
         case (state_q)
            ST_HOLD: begin
               if (hold_cnt_q == HC_W'(HOLD_CYC - 1)) begin
                  state_d    = (level_q == '0) ? ST_IDLE : ST_DECAY;
                  hold_cnt_d = '0;
                  div_cnt_d  = '0;
               end else begin
                  hold_cnt_d = hold_cnt_q + HC_W'(1);
               end
            end
            ST_DECAY: begin
               if (level_q == '0) begin
                  state_d   = ST_IDLE;
                  div_cnt_d = '0;
               end else if (div_cnt_q == DC_W'(DECAY_DIV - 1)) begin
                  level_d   = level_q - LVL_W'(1);
                  div_cnt_d = '0;
                  if (level_q == LVL_W'(1)) state_d = ST_IDLE;
               end else begin
                  div_cnt_d = div_cnt_q + DC_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level_q    <= '0;
         state_q    <= ST_IDLE;
         hold_cnt_q <= '0;
         div_cnt_q  <= '0;
         ovf_q      <= 1'b0;
         mode_q     <= MODE_TRACK;
         mode_vld_q <= 1'b0;
      end else begin
         level_q    <= level_d;
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
         div_cnt_q  <= div_cnt_d;
         ovf_q      <= ovf_d;
         mode_q     <= mode_d;
         mode_vld_q <= mode_vld_d;
      end
   end

   therm_enc #(
      .N_LEDS (N_LEDS),
      .LVL_W  (LVL_W)
   ) u_therm (
      .level (level_q),
      .therm (bus.L14)
   );

   assign bus.level = level_q;
   assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_led_bar_meter.sv
// Randomized and directed bench for led_bar_meter, compared every cycle
// against a closed-form peak/decay model of the bar level.
module tb_led_bar_meter;

   localparam int IN_W      = 2;
   localparam int N_LEDS    = 5;
   localparam int HOLD_CYC  = 3;
   localparam int DECAY_DIV = 2;
   localparam int LVL_W     = 3;

   logic clk;
   logic rst;

   led_bar_meter_if #(.IN_W(IN_W), .N_LEDS(N_LEDS), .LVL_W(LVL_W)) bus ();

   led_bar_meter #(
      .IN_W      (IN_W),
      .N_LEDS    (N_LEDS),
      .HOLD_CYC  (HOLD_CYC),
      .DECAY_DIV (DECAY_DIV),
      .LVL_W     (LVL_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // Model: level is the peak minus whole decay periods elapsed since capture.
   int m_lvl, m_peak, m_age, m_ovf;
   bit m_act, m_seen, m_pmode;

   task automatic check_val(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
      else            n_pass++;
   endtask

   task automatic model_reset();
      m_lvl = 0; m_peak = 0; m_age = 0; m_ovf = 0;
      m_act = 0; m_seen = 0; m_pmode = 0;
   endtask

   task automatic model_edge();
      int s, smp;
      s   = int'(bus.v1) + int'(bus.v2);
      smp = (s > N_LEDS) ? N_LEDS : s;
      if (bus.valid && s > N_LEDS) m_ovf = 1;
      else if (bus.clr_ovf)        m_ovf = 0;
      if (m_seen && bus.mode != m_pmode) begin
         m_act = 0;
      end else if (bus.mode == 1'b0) begin
         m_act = 0;
         if (bus.valid) m_lvl = smp;
      end else if (bus.valid && smp >= m_lvl) begin
         m_peak = smp; m_age = 0; m_act = 1; m_lvl = smp;
      end else if (m_act) begin
         m_age++;
         if (m_age >= HOLD_CYC) m_lvl = m_peak - (m_age - HOLD_CYC) / DECAY_DIV;
         if (m_lvl <= 0) begin m_lvl = 0; m_act = 0; end
      end
      m_pmode = bus.mode;
      m_seen  = 1;
   endtask

   task automatic check_model(input string tag);
      check_val({tag, ".level"}, int'(bus.level), m_lvl);
      check_val({tag, ".l14"},   int'(bus.L14),   (1 << m_lvl) - 1);
      check_val({tag, ".ovf"},   int'(bus.ovf),   m_ovf);
   endtask

   task automatic cyc(input bit vld, input int a, input int b, input bit md, input bit clr,
                      input string tag);
      bus.valid   = vld;
      bus.v1      = IN_W'(a);
      bus.v2      = IN_W'(b);
      bus.mode    = md;
      bus.clr_ovf = clr;
      @(posedge clk);
      model_edge();
      #1;
      check_model(tag);
   endtask

   int exp34 [11] = '{4, 4, 4, 4, 3, 3, 2, 2, 1, 1, 0};

   initial begin
      rst = 1'b1;
      bus.valid = 0; bus.v1 = 0; bus.v2 = 0; bus.mode = 0; bus.clr_ovf = 0;
      model_reset();
      #12;
      check_val("rst.level", int'(bus.level), 0);
      check_val("rst.l14",   int'(bus.L14),   0);
      check_val("rst.ovf",   int'(bus.ovf),   0);
      @(negedge clk);
      rst = 1'b0;

      // Track mode: plain capture, hold, overflow set/clear/priority
      cyc(1, 1, 2, 0, 0, "trk_cap");
      check_val("trk_cap.const_l14", int'(bus.L14), 5'b00111);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, "trk_hold");
      check_val("trk_hold.const", int'(bus.level), 3);
      cyc(1, 3, 3, 0, 0, "trk_sat");
      check_val("trk_sat.const_l14", int'(bus.L14), 5'b11111);
      check_val("trk_sat.const_ovf", int'(bus.ovf), 1);
      cyc(0, 0, 0, 0, 1, "ovf_clr");
      check_val("ovf_clr.const", int'(bus.ovf), 0);
      cyc(1, 3, 3, 0, 1, "ovf_setwins");
      check_val("ovf_setwins.const", int'(bus.ovf), 1);

      // Peak mode: capture 4, hold then decay to zero
      cyc(1, 0, 0, 0, 0, "to_zero");
      cyc(0, 0, 0, 1, 0, "mchg01");
      cyc(1, 2, 2, 1, 0, "pk_E0");
      check_val("pk_E0.const", int'(bus.level), 4);
      for (int e = 1; e <= 11; e++) begin
         cyc(0, 0, 0, 1, 0, "pk_decay");
         check_val($sformatf("pk_E%0d.const", e), int'(bus.level), exp34[e-1]);
      end

      // Smaller sample ignored, larger one restarts hold
      cyc(1, 2, 2, 1, 0, "rs_E0");
      cyc(1, 1, 1, 1, 0, "rs_E1_small");
      cyc(1, 3, 2, 1, 0, "rs_E2_big");
      for (int e = 3; e <= 7; e++) begin
         cyc(0, 0, 0, 1, 0, "rs_run");
         if (e == 6) check_val("rs_E6.const", int'(bus.level), 5);
         if (e == 7) check_val("rs_E7.const", int'(bus.level), 4);
      end

      // Mode 1->0 while decaying freezes the level
      cyc(0, 0, 0, 0, 0, "mchg10");
      for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0, "frozen");
      check_val("frozen.const", int'(bus.level), 4);

      // Asynchronous reset in the middle of a decay at level 3
      cyc(0, 0, 0, 1, 0, "mchg01b");
      cyc(1, 3, 3, 1, 0, "ar_cap");
      for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1, 0, "ar_decay");
      check_val("ar_pre.const", int'(bus.level), 3);
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_val("ar.level", int'(bus.level), 0);
      check_val("ar.l14",   int'(bus.L14),   0);
      check_val("ar.ovf",   int'(bus.ovf),   0);
      #1 rst = 1'b0;
      cyc(1, 1, 1, 1, 0, "post_rst_cap");
      check_val("post_rst_cap.const", int'(bus.level), 2);

      // Random traffic
      begin
         bit md;
         md = 1'b1;
         for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 29) == 0) md = ~md;
            cyc(($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), md, ($urandom_range(0, 7) == 0), "rnd");
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/led_bar_meter.md
LED_BAR_METER -- requirements
Module: led_bar_meter

Interface
REQ-001 Parameter IN_W, default 2: width of each unsigned operand.
REQ-002 Parameter N_LEDS, default 6: bar length; also the saturation ceiling of level.
REQ-003 Parameter HOLD_CYC, default 8, min 1: peak-hold cycles before decay starts.
REQ-004 Parameter DECAY_DIV, default 4, min 1: cycles per one-step decay.
REQ-005 Parameter LVL_W, derived as clog2(N_LEDS+1): width of level.
REQ-006 clk  input  1  single clock; all state changes on its rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 valid  input  1  qualifies v1/v2 for one cycle.
REQ-009 v1, v2  input  IN_W each  unsigned operands.
REQ-010 mode  input  1  0 = track, 1 = peak-hold with decay.
REQ-011 clr_ovf  input  1  clears the sticky overflow flag.
REQ-012 L14  output  N_LEDS  thermometer bar; bit i lit iff level > i.
REQ-013 level  output  LVL_W  current registered bar level.
REQ-014 ovf  output  1  sticky flag: some sampled sum exceeded N_LEDS.

Function
REQ-015 The sample shall be the IN_W+1-bit sum v1+v2, saturated to N_LEDS; no wrap-around.
REQ-016 level shall be the only value register; L14 shall decode level combinationally, so valid-to-L14 latency is 1 cycle.
REQ-017 FSM states: IDLE, HOLD, DECAY.
REQ-018 mode=0: FSM held in IDLE; on valid, level <= sample; otherwise level holds.
REQ-019 mode=1, valid with sample >= level: level <= sample, hold_cnt <= 0, state <= HOLD, whatever the current state.
REQ-020 mode=1, valid with sample < level: sample ignored; FSM continues.
REQ-021 HOLD: hold_cnt increments each cycle; at the edge where hold_cnt == HOLD_CYC-1, state <= DECAY and div_cnt <= 0.
REQ-022 DECAY: div_cnt increments each cycle; at the edge where div_cnt == DECAY_DIV-1, level decrements by 1 and div_cnt <= 0.
REQ-023 When a decrement leaves level at 0, state <= IDLE; level shall never underflow.
REQ-024 mode=1, IDLE, no valid: level holds.
REQ-025 A mode change shall leave level unchanged, force state to IDLE and clear both counters; the REQ-019 capture rule then applies from the next edge.
REQ-026 A capture on the same edge as a decay step shall take priority; that decrement is discarded.
REQ-027 ovf shall set on valid when the unsaturated sum > N_LEDS; clr_ovf clears it; on a simultaneous set and clear, set wins.

Reset
REQ-028 rst shall immediately force level=0, L14=0, ovf=0, state=IDLE, hold_cnt=0 and div_cnt=0, independent of clk, including mid-HOLD or mid-DECAY.
REQ-029 The first capture after rst deasserts shall occur at the first clk edge with valid=1.

Structure
REQ-030 Package led_meter_pkg shall hold the state enum (IDLE/HOLD/DECAY), the MODE_TRACK/MODE_PEAK constants and the clog2 width function.
REQ-031 Sub-module therm_enc (level -> N_LEDS-bit thermometer, purely combinational) shall be instantiated once.

Verification (bench: IN_W=2, N_LEDS=5, HOLD_CYC=3, DECAY_DIV=2)
REQ-032 mode=0, v1=1, v2=2, valid one cycle -> next cycle level=3, L14=00111, ovf=0; level=3 held afterwards.
REQ-033 mode=0, v1=3, v2=3 -> level=5, L14=11111, ovf=1; clr_ovf pulse -> ovf=0; clr_ovf together with a new overflow -> ovf stays 1.
REQ-034 mode=1, sum=4 captured at edge E0 -> level=4 through E4; 3 at E5, 2 at E7, 1 at E9, 0 at E11; state IDLE after E11.
REQ-035 mode=1, level=4 in HOLD, valid sum=2 -> ignored, timing unchanged; valid sum=5 at E2 -> level=5 and hold restarts (first decrement at E7).
REQ-036 rst asserted between clk edges mid-DECAY at level=3 -> level=0, L14=00000, ovf=0 before the next edge.
REQ-037 mode toggled 1->0 at level=4 in DECAY -> level stays 4 with no further decrement until the next valid.
